// File: rtl/cdb_arbiter.sv
// cdb_arbiter: writeback-stage collector in front of the physical register file.
// Each functional unit feeds a small private FIFO. Every cycle a round-robin
// scan grants up to CDB_WIDTH non-empty FIFO heads. The selected results are
// broadcast, registered, on the CDB slots.
// A cdb_tag slot is packed as {valid, index}.
module cdb_arbiter #(
    parameter int N_FU      = 5,
    parameter int CDB_WIDTH = 3,
    parameter int DEPTH     = 2,
    parameter int PREG_W    = 6,
    parameter int XLEN      = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                squash,
    input  logic [N_FU-1:0]                     fu_valid,
    input  logic [N_FU-1:0][PREG_W-1:0]         fu_tag,
    input  logic [N_FU-1:0][XLEN-1:0]           fu_value,
    output logic [N_FU-1:0]                     fu_ready,
    output logic [CDB_WIDTH-1:0][PREG_W:0]      cdb_tag,
    output logic [CDB_WIDTH-1:0][XLEN-1:0]      cdb_value
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RR_W   = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam int SLOT_W = $clog2(CDB_WIDTH + 1);

    logic [PREG_W-1:0]    fifo_tag [N_FU][DEPTH];
    logic [XLEN-1:0]      fifo_val [N_FU][DEPTH];
    logic [PTR_W-1:0]     head     [N_FU];
    logic [PTR_W-1:0]     tail     [N_FU];
    logic [CNT_W-1:0]     count    [N_FU];
    logic [RR_W-1:0]      rr_ptr;
    logic [RR_W-1:0]      rr_next;

    logic [N_FU-1:0]      push;
    logic [N_FU-1:0]      grant;
    logic                 any_grant;
    logic [RR_W-1:0]      last_src;
    logic [RR_W:0]        scan_sum;
    logic [RR_W-1:0]      scan_src;
    logic [SLOT_W-1:0]    used;

    logic [CDB_WIDTH-1:0][PREG_W:0] slot_tag;
    logic [CDB_WIDTH-1:0][XLEN-1:0] slot_val;

    // Pointers wrap modulo DEPTH. DEPTH is a power of two, so natural overflow
    // gives the wrap. The only exception is a single-entry FIFO, whose pointer
    // stays at 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (DEPTH == 1)
            return '0;
        else
            return p + PTR_W'(1);
    endfunction

    // Ready uses only the registered occupancy. Tag-0 results are taken but dropped.
    always_comb begin
        fu_ready = '0;
        push     = '0;
        for (int unsigned i = 0; i < N_FU; i++) begin
            fu_ready[i] = (count[i] < CNT_W'(DEPTH)) && !reset && !squash;
            push[i]     = fu_valid[i] && fu_ready[i] && (fu_tag[i] != '0);
        end
    end

    // Round-robin scan from rr_ptr. Grants are packed into CDB slots in scan order.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        last_src  = '0;
        slot_tag  = '0;
        slot_val  = '0;
        used      = '0;
        scan_sum  = '0;
        scan_src  = '0;
        for (int unsigned k = 0; k < N_FU; k++) begin
            scan_sum = {1'b0, rr_ptr} + (RR_W+1)'(k);
            scan_src = (scan_sum >= (RR_W+1)'(N_FU)) ? RR_W'(scan_sum - (RR_W+1)'(N_FU))
                                                     : scan_sum[RR_W-1:0];
            if ((count[scan_src] != '0) && (used < SLOT_W'(CDB_WIDTH))) begin
                grant[scan_src] = 1'b1;
                slot_tag[used]  = {1'b1, fifo_tag[scan_src][head[scan_src]]};
                slot_val[used]  = fifo_val[scan_src][head[scan_src]];
                any_grant       = 1'b1;
                last_src        = scan_src;
                used            = used + SLOT_W'(1);
            end
        end
    end

    // Next round-robin start: the source after the last one granted, with an explicit wrap.
    always_comb begin
        rr_next = rr_ptr;
        if (any_grant)
            rr_next = (last_src == RR_W'(N_FU - 1)) ? '0 : last_src + RR_W'(1);
    end

    // Occupancy, pointers, arbitration pointer and CDB registers. Reset and squash flush everything.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            for (int unsigned i = 0; i < N_FU; i++) begin
                count[i] <= '0;
                head[i]  <= '0;
                tail[i]  <= '0;
            end
            rr_ptr    <= '0;
            cdb_tag   <= '0;
            cdb_value <= '0;
        end else begin
            for (int unsigned i = 0; i < N_FU; i++) begin
                if (push[i])
                    tail[i] <= ptr_inc(tail[i]);
                if (grant[i])
                    head[i] <= ptr_inc(head[i]);
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(grant[i]);
            end
            rr_ptr    <= rr_next;
            cdb_tag   <= slot_tag;
            cdb_value <= slot_val;
        end
    end

    // FIFO storage needs no reset, because only entries counted by occupancy are ever read.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < N_FU; i++) begin
            if (push[i]) begin
                fifo_tag[i][tail[i]] <= fu_tag[i];
                fifo_val[i][tail[i]] <= fu_value[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed cycle table followed by a
// randomized run against a queue-based reference model.
module tb_cdb_arbiter;

    localparam int N_FU  = 5;
    localparam int CDBW  = 3;
    localparam int DEPTH = 2;
    localparam int PW    = 6;
    localparam int XW    = 32;

    logic                       clock = 1'b0;
    logic                       reset;
    logic                       squash;
    logic [N_FU-1:0]            fu_valid;
    logic [N_FU-1:0][PW-1:0]    fu_tag;
    logic [N_FU-1:0][XW-1:0]    fu_value;
    logic [N_FU-1:0]            fu_ready;
    logic [CDBW-1:0][PW:0]      cdb_tag;
    logic [CDBW-1:0][XW-1:0]    cdb_value;

    always #5 clock = ~clock;

    cdb_arbiter #(.N_FU(N_FU), .CDB_WIDTH(CDBW), .DEPTH(DEPTH), .PREG_W(PW), .XLEN(XW)) dut (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_value  (fu_value),
        .fu_ready  (fu_ready),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [XW-1:0] val_of(input logic [PW-1:0] t);
        return 32'hDEADBEE8 ^ {26'd0, t};
    endfunction

    // One directed cycle: inputs driven during the cycle and outputs expected in that same cycle.
    typedef struct {
        logic            rst;
        logic            sq;
        logic [4:0]      valid;
        logic [PW-1:0]   base;
        logic [4:0]      exp_ready;
        logic [2:0]      exp_v;
        logic [PW-1:0]   t0;
        logic [PW-1:0]   t1;
        logic [PW-1:0]   t2;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic sq, input logic [4:0] valid, input logic [PW-1:0] base,
                       input logic [4:0] er, input logic [2:0] ev,
                       input logic [PW-1:0] t0, input logic [PW-1:0] t1, input logic [PW-1:0] t2);
        vec_t v;
        v.rst = rst; v.sq = sq; v.valid = valid; v.base = base;
        v.exp_ready = er; v.exp_v = ev; v.t0 = t0; v.t1 = t1; v.t2 = t2;
        vecs.push_back(v);
    endtask

    // Reference model state
    logic [PW+XW-1:0]           mq[N_FU][$];
    int                         m_rr;
    logic [CDBW-1:0][PW:0]      m_tag;
    logic [CDBW-1:0][XW-1:0]    m_val;
    logic [N_FU-1:0]            m_ready;
    logic [N_FU-1:0]            xfer;

    initial begin
        vec_t                    v;
        logic [CDBW-1:0][PW:0]   e_tag;
        logic [CDBW-1:0][XW-1:0] e_val;
        logic [PW-1:0]           tj;
        logic [PW+XW-1:0]        ent;
        int                      ng;
        int                      last;

        // Per-source tag for each row = base + source index (mod 64).
        //  rst sq valid     base er        ev      t0  t1  t2
        add(0, 0, 5'b00100,  5, 5'b11111, 3'b000,  0,  0,  0); // src2 tag 7
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b000,  0,  0,  0);
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b001,  7,  0,  0);
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b000,  0,  0,  0);
        add(0, 1, 5'b00000,  0, 5'b00000, 3'b000,  0,  0,  0); // squash -> rr 0
        add(0, 0, 5'b11111, 10, 5'b11111, 3'b000,  0,  0,  0); // all sources
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b000,  0,  0,  0);
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b111, 10, 11, 12);
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b011, 13, 14,  0);
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b000,  0,  0,  0);
        add(0, 0, 5'b00010, 63, 5'b11111, 3'b000,  0,  0,  0); // src1 tag 0
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b000,  0,  0,  0);
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b000,  0,  0,  0);
        add(0, 0, 5'b11111, 20, 5'b11111, 3'b000,  0,  0,  0);
        add(0, 0, 5'b11111, 30, 5'b11111, 3'b000,  0,  0,  0);
        add(0, 1, 5'b11111, 40, 5'b00000, 3'b111, 20, 21, 22); // squash with valid
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b000,  0,  0,  0);
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b000,  0,  0,  0);
        add(0, 0, 5'b00001, 48, 5'b11111, 3'b000,  0,  0,  0); // src0 stream
        add(0, 0, 5'b00001, 49, 5'b11111, 3'b000,  0,  0,  0);
        add(0, 0, 5'b00001, 50, 5'b11111, 3'b001, 48,  0,  0);
        add(0, 0, 5'b00001, 51, 5'b11111, 3'b001, 49,  0,  0);
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b001, 50,  0,  0);
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b001, 51,  0,  0);
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b000,  0,  0,  0);
        add(0, 0, 5'b11111,  1, 5'b11111, 3'b000,  0,  0,  0); // fill up, rr=1
        add(0, 0, 5'b11111,  6, 5'b11111, 3'b000,  0,  0,  0);
        add(0, 0, 5'b00000,  0, 5'b01110, 3'b111,  2,  3,  4); // src0/src4 full
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b111,  5,  1,  7);
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b111,  8,  9, 10);
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b001,  6,  0,  0);
        add(0, 0, 5'b01000,  7, 5'b11111, 3'b000,  0,  0,  0); // src3 tag 10
        add(1, 0, 5'b00000,  0, 5'b00000, 3'b000,  0,  0,  0); // reset discards it
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b000,  0,  0,  0);
        add(0, 0, 5'b00000,  0, 5'b11111, 3'b000,  0,  0,  0);

        reset = 1'b1; squash = 1'b0; fu_valid = '0; fu_tag = '0; fu_value = '0;
        @(posedge clock); #1;
        @(negedge clock);
        check("reset_ready", 128'(fu_ready), 128'(0));
        check("reset_cdb_tag", 128'(cdb_tag), 128'(0));
        check("reset_cdb_value", 128'(cdb_value), 128'(0));
        @(posedge clock); #1;

        for (int r = 0; r < vecs.size(); r++) begin
            v = vecs[r];
            reset = v.rst; squash = v.sq; fu_valid = v.valid;
            for (int i = 0; i < N_FU; i++) begin
                tj = v.base + PW'(i);
                fu_tag[i]   = tj;
                fu_value[i] = val_of(tj);
            end
            @(negedge clock);
            e_tag = '0; e_val = '0;
            for (int j = 0; j < CDBW; j++) begin
                if (v.exp_v[j]) begin
                    tj = (j == 0) ? v.t0 : (j == 1) ? v.t1 : v.t2;
                    e_tag[j] = {1'b1, tj};
                    e_val[j] = val_of(tj);
                end
            end
            check($sformatf("row%0d_ready", r), 128'(fu_ready), 128'(v.exp_ready));
            check($sformatf("row%0d_cdb_tag", r), 128'(cdb_tag), 128'(e_tag));
            check($sformatf("row%0d_cdb_value", r), 128'(cdb_value), 128'(e_val));
            @(posedge clock); #1;
        end

        // Randomized phase; the DUT is empty with rr = 0 here.
        m_rr = 0; m_tag = '0; m_val = '0; xfer = '0;
        reset = 1'b0; squash = 1'b0; fu_valid = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            for (int i = 0; i < N_FU; i++)
                m_ready[i] = (mq[i].size() < DEPTH) && !reset && !squash;
            check("rnd_ready", 128'(fu_ready), 128'(m_ready));
            check("rnd_cdb_tag", 128'(cdb_tag), 128'(m_tag));
            check("rnd_cdb_value", 128'(cdb_value), 128'(m_val));

            // The model takes heads first; results arriving this cycle only join afterwards.
            xfer = fu_valid & m_ready;
            ng = 0; last = 0; e_tag = '0; e_val = '0;
            for (int k = 0; k < N_FU; k++) begin
                int s;
                s = (m_rr + k) % N_FU;
                if (mq[s].size() > 0 && ng < CDBW) begin
                    ent = mq[s].pop_front();
                    e_tag[ng] = {1'b1, ent[PW+XW-1:XW]};
                    e_val[ng] = ent[XW-1:0];
                    ng++;
                    last = s;
                end
            end
            if (ng > 0) m_rr = (last + 1) % N_FU;
            for (int i = 0; i < N_FU; i++)
                if (xfer[i] && fu_tag[i] != '0) mq[i].push_back({fu_tag[i], fu_value[i]});
            if (reset || squash) begin
                for (int i = 0; i < N_FU; i++) mq[i].delete();
                m_rr = 0; e_tag = '0; e_val = '0;
            end
            m_tag = e_tag; m_val = e_val;

            @(posedge clock); #1;
            reset  = ($urandom_range(0, 79) == 0);
            squash = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < N_FU; i++) begin
                if (!fu_valid[i] || xfer[i]) begin
                    fu_valid[i] = ($urandom_range(0, 3) != 0);
                    fu_tag[i]   = ($urandom_range(0, 9) == 0) ? PW'(0) : PW'($urandom_range(1, 63));
                    fu_value[i] = $urandom;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
